// File: rtl/fp_slab_reduce_pkg.sv
// Shared word layout, exception codes and ordering helpers
// for the ray/box slab reduction block.
package fp_slab_reduce_pkg;

  localparam int WIDTH = 36;

  localparam int EXC_HI  = 36;
  localparam int EXC_LO  = 35;
  localparam int SIGN    = 34;
  localparam int EXP_HI  = 33;
  localparam int EXP_LO  = 23;
  localparam int FRAC_HI = 22;
  localparam int FRAC_LO = 0;

  typedef logic [WIDTH:0] fp_word_t;

  typedef enum logic [1:0] {
    EXC_ZERO = 2'b00,
    EXC_NORM = 2'b01,
    EXC_INF  = 2'b10,
    EXC_NAN  = 2'b11
  } exc_e;

  typedef enum logic [1:0] {
    AX0 = 2'd0,
    AX1 = 2'd1,
    AX2 = 2'd2,
    OUT = 2'd3
  } state_e;

  localparam fp_word_t FP_ZERO = '0;

  // Total order classes, smallest first.
  localparam logic [2:0] R_NINF = 3'd0;
  localparam logic [2:0] R_NEG  = 3'd1;
  localparam logic [2:0] R_ZERO = 3'd2;
  localparam logic [2:0] R_POS  = 3'd3;
  localparam logic [2:0] R_PINF = 3'd4;

  function automatic logic fp_is_nan(
    input fp_word_t a
  );
    return a[EXC_HI:EXC_LO] == EXC_NAN;
  endfunction

  function automatic logic [2:0] fp_rank(
    input fp_word_t a
  );
    logic [2:0] r;
    r = R_ZERO;
    case (a[EXC_HI:EXC_LO])
      EXC_NORM: r = a[SIGN] ? R_NEG : R_POS;
      EXC_INF:  r = a[SIGN] ? R_NINF : R_PINF;
      default:  r = R_ZERO;
    endcase
    return r;
  endfunction

  // Strict a > b; any NaN operand yields 0.
  function automatic logic fp_gt(
    input fp_word_t a,
    input fp_word_t b
  );
    logic [2:0] ra;
    logic [2:0] rb;
    logic       res;
    ra  = fp_rank(a);
    rb  = fp_rank(b);
    res = 1'b0;
    if (fp_is_nan(a) || fp_is_nan(b))
      res = 1'b0;
    else if (ra != rb)
      res = ra > rb;
    else if (ra == R_POS)
      res = a[EXP_HI:FRAC_LO] > b[EXP_HI:FRAC_LO];
    else if (ra == R_NEG)
      res = a[EXP_HI:FRAC_LO] < b[EXP_HI:FRAC_LO];
    return res;
  endfunction

  function automatic logic fp_le(
    input fp_word_t a,
    input fp_word_t b
  );
    return ~fp_is_nan(a) & ~fp_is_nan(b)
         & ~fp_gt(a, b);
  endfunction

endpackage

// File: rtl/fp_slab_reduce_greater.sv
// Combinational ordering compare of two FloPoCo words,
// with a NaN flag covering both operands.
module fp_greater
  import fp_slab_reduce_pkg::*;
(
  input  fp_word_t inA,
  input  fp_word_t inB,
  output logic     gt,
  output logic     either_nan
);

  assign either_nan = fp_is_nan(inA)
                    | fp_is_nan(inB);

  assign gt = fp_gt(inA, inB);

endmodule

// File: rtl/fp_slab_reduce.sv
// Reduces three axis slab intervals to [t_near, t_far]
// and a hit flag, one axis pair accepted per cycle.
module fp_slab_reduce
  import fp_slab_reduce_pkg::*;
#(
  parameter int width = WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [width:0] in_tmin,
  input  logic [width:0] in_tmax,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [width:0] t_near,
  output logic [width:0] t_far,
  output logic           hit,
  output logic           nan_seen
);

  state_e state;
  state_e state_nx;

  logic accept;
  logic near_gt;
  logic near_nan;
  logic far_gt;
  logic far_nan;
  logic in_nan;

  logic [width:0] near_nx;
  logic [width:0] far_nx;
  logic           nan_nx;
  logic           hit_nx;

  assign in_ready  = state != OUT;
  assign out_valid = state == OUT;
  assign accept    = in_valid & in_ready;

  fp_greater u_max (
    .inA        (in_tmin),
    .inB        (t_near),
    .gt         (near_gt),
    .either_nan (near_nan)
  );

  fp_greater u_min (
    .inA        (t_far),
    .inB        (in_tmax),
    .gt         (far_gt),
    .either_nan (far_nan)
  );

  assign in_nan = fp_is_nan(in_tmin)
                | fp_is_nan(in_tmax);

  // Ties and NaN operands never replace the held value.
  always_comb begin
    near_nx = t_near;
    far_nx  = t_far;
    nan_nx  = nan_seen | in_nan;
    if (state == AX0) begin
      near_nx = in_tmin;
      far_nx  = in_tmax;
      nan_nx  = in_nan;
    end else begin
      if (near_gt && !near_nan)
        near_nx = in_tmin;
      if (far_gt && !far_nan)
        far_nx = in_tmax;
    end
  end

  assign hit_nx = fp_le(near_nx, far_nx)
                & ~fp_gt(FP_ZERO, far_nx)
                & ~nan_nx;

  always_comb begin
    state_nx = state;
    unique case (state)
      AX0: if (accept) state_nx = AX1;
      AX1: if (accept) state_nx = AX2;
      AX2: if (accept) state_nx = OUT;
      OUT: if (out_ready) state_nx = AX0;
      default: state_nx = AX0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= AX0;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_near   <= '0;
      t_far    <= '0;
      nan_seen <= 1'b0;
      hit      <= 1'b0;
    end else if (accept) begin
      t_near   <= near_nx;
      t_far    <= far_nx;
      nan_seen <= nan_nx;
      if (state == AX2)
        hit <= hit_nx;
    end
  end

endmodule

// File: tb/tb_fp_slab_reduce.sv
// Directed bench for fp_slab_reduce: hand-computed
// ray/box vectors, stalls and mid-ray reset.
module tb_fp_slab_reduce;

  localparam logic [36:0] P0    = 37'h0000000000;
  localparam logic [36:0] N0    = 37'h0400000000;
  localparam logic [36:0] P1    = 37'h09FF800000;
  localparam logic [36:0] N1    = 37'h0DFF800000;
  localparam logic [36:0] P2    = 37'h0A00000000;
  localparam logic [36:0] P3    = 37'h0A00400000;
  localparam logic [36:0] PINF  = 37'h1000000000;
  localparam logic [36:0] NINF  = 37'h1400000000;
  localparam logic [36:0] QNAN  = 37'h1800000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [36:0] in_tmin = '0;
  logic [36:0] in_tmax = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [36:0] t_near;
  logic [36:0] t_far;
  logic        hit;
  logic        nan_seen;

  int checks = 0;
  int errors = 0;

  fp_slab_reduce #(.width(36)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_tmin   (in_tmin),
    .in_tmax   (in_tmax),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .t_near    (t_near),
    .t_far     (t_far),
    .hit       (hit),
    .nan_seen  (nan_seen)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic send(
    input logic [36:0] a,
    input logic [36:0] b
  );
    in_valid = 1'b1;
    in_tmin  = a;
    in_tmax  = b;
    check("in_ready_ax", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic ray(
    input logic [36:0] a0, input logic [36:0] b0,
    input logic [36:0] a1, input logic [36:0] b1,
    input logic [36:0] a2, input logic [36:0] b2
  );
    send(a0, b0);
    send(a1, b1);
    send(a2, b2);
  endtask

  task automatic expect_out(
    input string       tag,
    input logic [36:0] near,
    input logic [36:0] far,
    input logic        h,
    input logic        n
  );
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_rdy"}, 64'(in_ready), 64'd0);
    check({tag, "_near"}, 64'(t_near), 64'(near));
    check({tag, "_far"}, 64'(t_far), 64'(far));
    check({tag, "_hit"}, 64'(hit), 64'(h));
    check({tag, "_nan"}, 64'(nan_seen), 64'(n));
  endtask

  // Offers a junk pair during the drain cycle; it must
  // not be taken.
  task automatic drain;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_tmin   = PINF;
    in_tmax   = NINF;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("drain_valid", 64'(out_valid), 64'd0);
    check("drain_rdy", 64'(in_ready), 64'd1);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_near", 64'(t_near), 64'd0);
    check("rst_far", 64'(t_far), 64'd0);
    check("rst_hit", 64'(hit), 64'd0);
    check("rst_nan", 64'(nan_seen), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    check("idle_valid", 64'(out_valid), 64'd0);

    ray(P1, P3, P0, P2, N1, P3);
    expect_out("basic", P1, P2, 1'b1, 1'b0);
    drain();

    ray(P2, P3, N1, P1, P0, P3);
    expect_out("miss", P2, P1, 1'b0, 1'b0);
    drain();

    ray(P1, P3, QNAN, P2, P0, P3);
    expect_out("nan", P1, P2, 1'b0, 1'b1);
    drain();

    ray(NINF, PINF, NINF, PINF, NINF, PINF);
    expect_out("inf", NINF, PINF, 1'b1, 1'b0);
    drain();

    ray(NINF, N1, NINF, N1, NINF, N1);
    expect_out("behind", NINF, N1, 1'b0, 1'b0);
    drain();

    // -0 ties +0: held +0 must survive.
    ray(P0, P3, N0, P3, N1, P3);
    expect_out("zero_tie", P0, P3, 1'b1, 1'b0);
    drain();

    ray(P1, P3, P0, P2, N1, P3);
    for (int i = 0; i < 5; i++) begin
      expect_out("stall", P1, P2, 1'b1, 1'b0);
      @(negedge clk);
    end
    expect_out("stall_end", P1, P2, 1'b1, 1'b0);
    drain();

    send(PINF, PINF);
    send(PINF, PINF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_near", 64'(t_near), 64'd0);
    check("mid_rst_rdy", 64'(in_ready), 64'd1);
    ray(P2, P3, N1, P1, P0, P3);
    expect_out("after_rst", P2, P1, 1'b0, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
